medication_event_logger: RTL and testbench
==========================================

Name: medication_event_logger

Overview:
- Observing side of the medication box alarm interface. Monitors the box's shouldEat alarm lines, the patient button lines and the notify (missed-dose) pulses.
- Converts each alarm-raised, dose-taken and dose-missed occurrence into a timestamped 9-bit event record.
- Records are buffered in a FIFO and read out by a caregiver/display unit over a valid/ready handshake.
- Keeps its own hour-of-day counter, advanced by an external hour tick.

Parameters:
DEPTH, 8, FIFO entries (power of two, >=2)
CNT_W, 4, width of the fill-level output (must hold DEPTH)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
hour_tick  input  1  single-cycle pulse, advance hour counter
shouldEat  input  4  per-drug alarm level from medication box
button  input  4  per-drug patient acknowledge
notify  input  4  per-drug missed-dose pulse
ev_ready  input  1  consumer accepts head record
clr_ovf  input  1  clears overflow flag
ev_valid  output  1  FIFO non-empty
ev_data  output  9  head record {type[1:0], drug[1:0], hour[4:0]}
level  output  CNT_W  number of stored records
overflow  output  1  sticky lost-event flag
hour  output  5  current hour 0..23

Behaviour:
- Reset (async, rst=1): hour=0, FIFO empty, ev_valid=0, ev_data=0, level=0, overflow=0. All pending bits and edge-history registers are 0. Reset mid-operation discards all stored and pending events.
- Hour counter: increments on hour_tick; 23 -> 0 wrap.
- Edge history: prev_se, prev_btn, prev_nt are registered copies of shouldEat, button and notify.
- Detection, evaluated per drug i each cycle:
  - ALARM (type 01): shouldEat[i] & ~prev_se[i].
  - TAKEN (type 10): button[i] & ~prev_btn[i] & shouldEat[i]. A button held over several cycles logs once. A button press with shouldEat low logs nothing.
  - MISSED (type 11): notify[i] & ~prev_nt[i].
  - Type 00 is never emitted.
- Pending vector: 12 bits, one per (type, drug).
  - A detection sets its bit.
  - If the bit is already set, the new occurrence is lost and overflow is set.
  - Any number of detections in the same cycle are all captured.
- Arbiter: selects one pending bit per cycle.
  - Priority: MISSED > TAKEN > ALARM; within a type, lowest drug index first.
  - A push is allowed when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - On push: write {type, drug, hour}, where hour is the value at the push cycle, and clear that pending bit.
  - If a detection and a clear target the same bit in the same cycle, the bit stays set (a new occurrence is queued).
- Latency: an event detected in cycle N (inputs sampled at edge N) is pushed at edge N+1 if it wins arbitration and space exists. It is visible on ev_valid/ev_data after edge N+1.
- FIFO read side:
  - First-word fall-through: ev_data always shows the head; it holds its last value when empty.
  - Pop occurs when ev_valid & ev_ready.
  - level: +1 on push only, -1 on pop only, unchanged on push and pop together.
  - Pointers are log2(DEPTH) bits and wrap naturally. Full is level==DEPTH; empty is level==0.
- Full FIFO: no record is dropped directly. Events stay pending (backpressure). Loss occurs only on a pending-bit collision, which sets overflow.
- overflow: sticky; cleared by clr_ovf. If set and clear occur in the same cycle, set wins.
- ev_ready while empty: ignored; no pointer movement.

Test Plan:
1. Reset, 3 hour_ticks, then shouldEat 0000->0100 -> one record 0x1_2_03 = {01,10,00011}, ev_valid=1 after one cycle, level=1. With ev_ready=1 it pops and level returns to 0.
2. shouldEat[0] high, button[0] held 5 cycles at hour 5 -> exactly one TAKEN record {10,00,00101}. A button[1] press with shouldEat[1]=0 -> no record.
3. notify=1011 and shouldEat rising on drug 2, same cycle, ev_ready=1 -> records emitted in order MISSED d0, MISSED d1, MISSED d3, ALARM d2, one per cycle.
4. ev_ready=0; generate 8 distinct events -> level=8, ev_valid=1. A 9th distinct event stays pending with overflow=0. Repeating that same event while still pending -> overflow=1. One pop then lets the pending event push, level stays 8. clr_ovf -> overflow=0.
5. 24 hour_ticks from reset -> hour 0..23 then 0. An event logged after the 24th tick carries hour 0.
6. Assert rst asynchronously between clock edges with level=5 and pending bits set -> immediately ev_valid=0, level=0, overflow=0, hour=0. No stale records appear after rst is released.

Source files
------------

// File: rtl/medication_event_logger.sv
// Medication event logger: turns alarm, dose-taken and missed-dose edges into
// timestamped 9-bit records {type, drug, hour} and queues them for a reader.
module medication_event_logger #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hour_tick,
   input  logic [3:0]       shouldEat,
   input  logic [3:0]       button,
   input  logic [3:0]       notify,
   input  logic             ev_ready,
   input  logic             clr_ovf,
   output logic             ev_valid,
   output logic [8:0]       ev_data,
   output logic [CNT_W-1:0] level,
   output logic             overflow,
   output logic [4:0]       hour
);

   localparam int unsigned PtrW = $clog2(DEPTH);

   logic [4:0]       hour_q, hour_d;
   logic [3:0]       prev_se_q, prev_btn_q, prev_nt_q;
   // Pending bits: [3:0] ALARM, [7:4] TAKEN, [11:8] MISSED, drug index within each nibble
   logic [11:0]      pend_q, pend_d;
   logic [11:0]      det, sel, clr;
   logic             ovf_q, ovf_d;
   logic [8:0]       mem_q [DEPTH];
   logic [PtrW-1:0]  wptr_q, rptr_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [8:0]       last_q;
   logic [8:0]       rec;
   logic             found, full, empty, pop, push;

   // Rising-edge detection per drug; TAKEN only counts while the alarm is up
   always_comb begin
      det[3:0]  = shouldEat & ~prev_se_q;
      det[7:4]  = button & ~prev_btn_q & shouldEat;
      det[11:8] = notify & ~prev_nt_q;
   end

   // Fixed-priority arbiter: MISSED > TAKEN > ALARM, lowest drug first
   always_comb begin
      sel   = '0;
      found = 1'b0;
      rec   = '0;
      for (int g = 2; g >= 0; g--) begin
         for (int d = 0; d < 4; d++) begin
            if (!found && pend_q[g*4+d]) begin
               found        = 1'b1;
               sel[g*4+d]   = 1'b1;
               rec          = {2'(g + 1), 2'(d), hour_q};
            end
         end
      end
   end

   // FIFO status, handshake and pending/overflow next state
   always_comb begin
      empty  = (cnt_q == '0);
      full   = (cnt_q == CNT_W'(DEPTH));
      pop    = !empty && ev_ready;
      push   = found && (!full || pop);
      clr    = push ? sel : '0;
      // A detection landing on a bit being cleared this cycle is queued, not lost
      pend_d = (pend_q & ~clr) | det;
      ovf_d  = (|(det & pend_q & ~clr)) | (ovf_q & ~clr_ovf);
      hour_d = hour_tick ? ((hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1) : hour_q;
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Control state: hour, edge history, pending, overflow, pointers, level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hour_q     <= '0;
         prev_se_q  <= '0;
         prev_btn_q <= '0;
         prev_nt_q  <= '0;
         pend_q     <= '0;
         ovf_q      <= 1'b0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         last_q     <= '0;
      end else begin
         hour_q     <= hour_d;
         prev_se_q  <= shouldEat;
         prev_btn_q <= button;
         prev_nt_q  <= notify;
         pend_q     <= pend_d;
         ovf_q      <= ovf_d;
         cnt_q      <= cnt_d;
         if (push) wptr_q <= wptr_q + PtrW'(1);
         if (pop) begin
            rptr_q <= rptr_q + PtrW'(1);
            last_q <= mem_q[rptr_q];
         end
      end
   end

   // Record storage; contents are only meaningful between the pointers
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= rec;
   end

   // First-word fall-through head; holds the last popped record when empty
   always_comb begin
      ev_valid = !empty;
      ev_data  = empty ? last_q : mem_q[rptr_q];
      level    = cnt_q;
      overflow = ovf_q;
      hour     = hour_q;
   end

endmodule

// File: tb/tb_medication_event_logger.sv
// Self-checking bench for medication_event_logger: directed scenarios plus
// randomized traffic against a queue-based behavioural model.
module tb_medication_event_logger;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             hour_tick = 1'b0;
   logic [3:0]       shouldEat = '0;
   logic [3:0]       button = '0;
   logic [3:0]       notify = '0;
   logic             ev_ready = 1'b0;
   logic             clr_ovf = 1'b0;
   logic             ev_valid;
   logic [8:0]       ev_data;
   logic [CNT_W-1:0] level;
   logic             overflow;
   logic [4:0]       hour;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   medication_event_logger #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .hour_tick (hour_tick),
      .shouldEat (shouldEat),
      .button    (button),
      .notify    (notify),
      .ev_ready  (ev_ready),
      .clr_ovf   (clr_ovf),
      .ev_valid  (ev_valid),
      .ev_data   (ev_data),
      .level     (level),
      .overflow  (overflow),
      .hour      (hour)
   );

   // Behavioural model: record queue, pending table [group][drug], group 0/1/2 = ALARM/TAKEN/MISSED
   bit [8:0] mq[$];
   bit [8:0] m_last;
   bit       m_pend[3][4];
   int       m_hour;
   bit       m_ovf;
   bit [3:0] m_pse, m_pbtn, m_pnt;

   function automatic void model_reset();
      mq.delete();
      m_last = '0;
      foreach (m_pend[g, d]) m_pend[g][d] = 1'b0;
      m_hour = 0;
      m_ovf  = 1'b0;
      m_pse  = '0;
      m_pbtn = '0;
      m_pnt  = '0;
   endfunction

   function automatic void model_edge();
      bit pop, push, ovf_set;
      int wg, wd;
      bit det[3][4];
      pop = (mq.size() > 0) && ev_ready;
      wg = -1;
      wd = -1;
      for (int g = 2; g >= 0; g--)
         for (int d = 0; d < 4; d++)
            if (wg < 0 && m_pend[g][d]) begin
               wg = g;
               wd = d;
            end
      push = (wg >= 0) && ((mq.size() < int'(DEPTH)) || pop);
      for (int d = 0; d < 4; d++) begin
         det[0][d] = shouldEat[d] && !m_pse[d];
         det[1][d] = button[d] && !m_pbtn[d] && shouldEat[d];
         det[2][d] = notify[d] && !m_pnt[d];
      end
      if (pop) m_last = mq.pop_front();
      if (push) begin
         mq.push_back({2'(wg + 1), 2'(wd), 5'(m_hour)});
         m_pend[wg][wd] = 1'b0;
      end
      ovf_set = 1'b0;
      for (int g = 0; g < 3; g++)
         for (int d = 0; d < 4; d++)
            if (det[g][d]) begin
               if (m_pend[g][d]) ovf_set = 1'b1;
               m_pend[g][d] = 1'b1;
            end
      if (ovf_set) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      if (hour_tick) m_hour = (m_hour + 1) % 24;
      m_pse  = shouldEat;
      m_pbtn = button;
      m_pnt  = notify;
   endfunction

   function automatic logic [19:0] exp_vec();
      logic [8:0] hd;
      logic       v;
      v  = mq.size() > 0;
      hd = v ? mq[0] : m_last;
      return {v, hd, CNT_W'(mq.size()), m_ovf, 5'(m_hour)};
   endfunction

   function automatic logic [19:0] dut_vec();
      return {ev_valid, ev_data, level, overflow, hour};
   endfunction

   // One clock: model follows the edge unless reset is held; sample 1 time unit later
   task automatic step();
      @(posedge clk);
      if (!rst) model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      model_reset();
      n_tests++;
      if (dut_vec() !== 20'h0) begin
         n_fail++;
         $display("FAIL reset_state got %h want %h", dut_vec(), 20'h0);
      end
      step();
      step();
      rst = 1'b0;
      step();
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_idle got %h want %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_alarm_basic();
      hour_tick = 1'b1;
      repeat (3) step();
      hour_tick = 1'b0;
      shouldEat = 4'b0100;
      step();
      n_tests++;
      if (ev_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL alarm_latency ev_valid got %b want 0", ev_valid);
      end
      step();
      n_tests++;
      if (ev_valid !== 1'b1 || ev_data !== 9'h0C3 || level !== 4'd1) begin
         n_fail++;
         $display("FAIL alarm_record got v=%b d=%h l=%0d want v=1 d=0c3 l=1",
                  ev_valid, ev_data, level);
      end
      ev_ready = 1'b1;
      step();
      ev_ready = 1'b0;
      n_tests++;
      if (level !== 4'd0 || dut_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL alarm_pop got %h want %h", dut_vec(), exp_vec());
      end
      shouldEat = 4'b0000;
      step();
   endtask

   task automatic test_taken_once();
      hour_tick = 1'b1;
      repeat (2) step();
      hour_tick = 1'b0;
      shouldEat = 4'b0001;
      step();
      button = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         step();
         n_tests++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL taken_hold[%0d] got %h want %h", i, dut_vec(), exp_vec());
         end
      end
      button = 4'b0000;
      step();
      button = 4'b0010;
      step();
      button = 4'b0000;
      repeat (3) step();
      n_tests++;
      if (level !== 4'd2 || ev_data !== 9'h085) begin
         n_fail++;
         $display("FAIL taken_count got l=%0d d=%h want l=2 d=085", level, ev_data);
      end
      ev_ready = 1'b1;
      step();
      ev_ready = 1'b0;
      n_tests++;
      if (level !== 4'd1 || ev_data !== 9'h105) begin
         n_fail++;
         $display("FAIL taken_record got l=%0d d=%h want l=1 d=105", level, ev_data);
      end
      ev_ready = 1'b1;
      step();
      ev_ready = 1'b0;
      shouldEat = 4'b0000;
      step();
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL taken_drain got %h want %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_priority();
      logic [8:0] got[$];
      logic [8:0] want[4];
      want[0] = 9'h185;
      want[1] = 9'h1A5;
      want[2] = 9'h1E5;
      want[3] = 9'h0C5;
      ev_ready  = 1'b1;
      notify    = 4'b1011;
      shouldEat = 4'b0100;
      step();
      notify = 4'b0000;
      for (int i = 0; i < 12; i++) begin
         step();
         if (ev_valid) got.push_back(ev_data);
      end
      n_tests++;
      if (got.size() != 4) begin
         n_fail++;
         $display("FAIL priority_count got %0d want 4", got.size());
      end
      for (int i = 0; i < 4; i++) begin
         if (i < got.size()) begin
            n_tests++;
            if (got[i] !== want[i]) begin
               n_fail++;
               $display("FAIL priority_order[%0d] got %h want %h", i, got[i], want[i]);
            end
         end
      end
      ev_ready  = 1'b0;
      shouldEat = 4'b0000;
      step();
   endtask

   task automatic test_full_backpressure();
      ev_ready  = 1'b0;
      shouldEat = 4'b1111;
      notify    = 4'b1111;
      step();
      notify = 4'b0000;
      repeat (9) step();
      n_tests++;
      if (level !== 4'd8 || ev_valid !== 1'b1 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL full_level got l=%0d v=%b o=%b want l=8 v=1 o=0", level, ev_valid, overflow);
      end
      button = 4'b0001;
      repeat (2) step();
      n_tests++;
      if (level !== 4'd8 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL full_pending got l=%0d o=%b want l=8 o=0", level, overflow);
      end
      button = 4'b0000;
      step();
      button = 4'b0001;
      step();
      step();
      n_tests++;
      if (overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL full_collision overflow got %b want 1", overflow);
      end
      ev_ready = 1'b1;
      step();
      ev_ready = 1'b0;
      step();
      n_tests++;
      if (level !== 4'd8 || dut_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL full_pop_push got %h want %h", dut_vec(), exp_vec());
      end
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      n_tests++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_ovf overflow got %b want 0", overflow);
      end
      ev_ready = 1'b1;
      button   = 4'b0000;
      shouldEat = 4'b0000;
      repeat (10) step();
      ev_ready = 1'b0;
      n_tests++;
      if (dut_vec() !== exp_vec() || level !== 4'd0) begin
         n_fail++;
         $display("FAIL full_drain got %h want %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_hour_wrap();
      rst = 1'b1;
      #1;
      model_reset();
      step();
      rst = 1'b0;
      hour_tick = 1'b1;
      for (int i = 1; i <= 24; i++) begin
         step();
         n_tests++;
         if (hour !== 5'(i % 24)) begin
            n_fail++;
            $display("FAIL hour_tick[%0d] got %0d want %0d", i, hour, i % 24);
         end
      end
      hour_tick = 1'b0;
      shouldEat = 4'b0010;
      repeat (2) step();
      n_tests++;
      if (ev_valid !== 1'b1 || ev_data !== 9'h0A0) begin
         n_fail++;
         $display("FAIL hour_wrap_record got v=%b d=%h want v=1 d=0a0", ev_valid, ev_data);
      end
      shouldEat = 4'b0000;
      ev_ready  = 1'b1;
      step();
      ev_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      ev_ready  = 1'b0;
      shouldEat = 4'b1111;
      notify    = 4'b1111;
      step();
      notify = 4'b0000;
      repeat (5) step();
      n_tests++;
      if (level !== 4'd5) begin
         n_fail++;
         $display("FAIL async_prefill level got %0d want 5", level);
      end
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      model_reset();
      n_tests++;
      if ({ev_valid, level, overflow, hour} !== 11'h0) begin
         n_fail++;
         $display("FAIL async_reset got v=%b l=%0d o=%b h=%0d want all 0",
                  ev_valid, level, overflow, hour);
      end
      shouldEat = 4'b0000;
      repeat (2) step();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         n_tests++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL async_stale[%0d] got %h want %h", i, dut_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(3) == 0) shouldEat[$urandom_range(3)] ^= 1'b1;
         button    = 4'($urandom);
         notify    = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0000;
         ev_ready  = ($urandom_range(2) == 0);
         hour_tick = ($urandom_range(7) == 0);
         clr_ovf   = ($urandom_range(15) == 0);
         step();
         n_tests++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL random[%0d] got %h want %h", i, dut_vec(), exp_vec());
         end
      end
      hour_tick = 1'b0;
      clr_ovf   = 1'b0;
      ev_ready  = 1'b0;
   endtask

   initial begin
      #1;
      test_reset();
      test_alarm_basic();
      test_taken_once();
      test_priority();
      test_full_backpressure();
      test_hour_wrap();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
